// File: rtl/sar_ctrl_if.sv
// sar_ctrl_if: step clock, conversion request and comparator decision toward the
// controller; sampling switch, DAC trial code and conversion result back out.
interface sar_ctrl_if #(
    parameter int NBIT = 8
);
    logic            cks;
    logic            start;
    logic            cmp;
    logic            smpl;
    logic [NBIT-1:0] dac;
    logic [NBIT-1:0] dout;
    logic            valid;
    logic            busy;

    modport master (
        output cks, start, cmp,
        input  smpl, dac, dout, valid, busy
    );

    modport slave (
        input  cks, start, cmp,
        output smpl, dac, dout, valid, busy
    );
endinterface

// File: rtl/sar_ctrl.sv
// sar_ctrl: successive-approximation controller; samples for SAMPLE_TICKS step
// ticks, then resolves one DAC bit per rising edge of the divided clock CKS.
module sar_ctrl #(
    parameter int NBIT         = 8,
    parameter int SAMPLE_TICKS = 2
) (
    input  logic      i_ck,
    input  logic      i_rst,
    sar_ctrl_if.slave bus
);
    localparam int              IW       = (NBIT > 1) ? $clog2(NBIT) : 1;
    localparam logic [IW-1:0]   IDX_TOP  = IW'(NBIT - 1);
    localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
    localparam logic [NBIT-1:0] MSB_CODE = {1'b1, {(NBIT-1){1'b0}}};
    localparam logic [4:0]      CNT_END  = 5'(SAMPLE_TICKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMPLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic            r_cksQ;
    logic            w_tick;
    logic [3:0]      r_cnt;
    logic [3:0]      w_nextCnt;
    logic [4:0]      w_cntInc;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_nextIdx;
    logic [NBIT-1:0] r_dac;
    logic [NBIT-1:0] w_nextDac;
    logic [NBIT-1:0] r_dout;
    logic [NBIT-1:0] w_nextDout;

    // One step per CKS rising edge; a static CKS simply stalls the sequence.
    assign w_tick   = bus.cks & ~r_cksQ;
    assign w_cntInc = {1'b0, r_cnt} + 5'd1;

    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cksQ  <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= IDX_TOP;
            r_dac   <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_nextState;
            r_cksQ  <= bus.cks;
            r_cnt   <= w_nextCnt;
            r_idx   <= w_nextIdx;
            r_dac   <= w_nextDac;
            r_dout  <= w_nextDout;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextIdx   = r_idx;
        w_nextDac   = r_dac;
        w_nextDout  = r_dout;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_nextState = S_SAMPLE;
                    w_nextCnt   = '0;
                end
            end
            S_SAMPLE: begin
                if (w_tick) begin
                    w_nextCnt = w_cntInc[3:0];
                    if (w_cntInc == CNT_END) begin
                        w_nextState = S_CONV;
                        w_nextDac   = MSB_CODE;
                        w_nextIdx   = IDX_TOP;
                    end
                end
            end
            S_CONV: begin
                // Resolve the current bit and arm the next trial bit on the same edge.
                if (w_tick) begin
                    w_nextDac[r_idx] = bus.cmp;
                    if (r_idx != '0) begin
                        w_nextDac[r_idx - IDX_ONE] = 1'b1;
                        w_nextIdx                  = r_idx - IDX_ONE;
                    end else begin
                        w_nextDout  = w_nextDac;
                        w_nextState = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign bus.smpl  = (r_state == S_SAMPLE);
    assign bus.busy  = (r_state == S_SAMPLE) || (r_state == S_CONV);
    assign bus.valid = (r_state == S_DONE);
    assign bus.dac   = r_dac;
    assign bus.dout  = r_dout;
endmodule
